// File: rtl/clktick_multi.sv
// clktick_multi -- multi-channel programmable tick generator.
//
// NCH independent down-counting timers share one clock and one global step
// strobe. Each channel loads its reload value on start, counts down once per
// step, and emits a registered one-cycle tick on the step where the count is
// already zero. Periodic channels reload and keep running; one-shot channels
// return to IDLE on that same edge.
//
// Optional feature macro: CLKTICK_PRESCALE_EN
//   When defined, a shared prescaler divides en by (pre+1) to form the step
//   strobe, and parameter PWIDTH and port pre are added.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   en     in   global count enable
//   n      in   packed reload values, channel i at n[i*WIDTH +: WIDTH]
//   mode   in   per channel: 1 = periodic, 0 = one-shot
//   start  in   per channel load/restart request (level-sampled)
//   stop   in   per channel abort request (level-sampled, beats start)
//   pre    in   prescaler reload (CLKTICK_PRESCALE_EN only)
//   tick   out  registered one-cycle terminal pulse per channel
//   busy   out  registered, high while the channel is in RUN

module clktick_chan #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [WIDTH-1:0] n,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count, count_nx;
  logic             tick_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      tick  <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    tick_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        // Load edge only; the first decrement happens on the next step.
        if (start) begin
          count_nx = n;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (start) begin
          count_nx = n;
        end else if (step) begin
          if (count == '0) begin
            tick_nx = 1'b1;
            if (mode) count_nx = n;
            else      state_nx = IDLE;
          end else begin
            count_nx = count - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register doubles as the busy flop.
  assign busy = (state == RUN);
endmodule

module clktick_multi #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4
`ifdef CLKTICK_PRESCALE_EN
 ,parameter int PWIDTH = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] n,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
`ifdef CLKTICK_PRESCALE_EN
  input  logic [PWIDTH-1:0]    pre,
`endif
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       busy
);
  logic step;

`ifdef CLKTICK_PRESCALE_EN
  // Free-running divider, independent of channel state, so step phase is
  // not aligned to any channel's start.
  logic [PWIDTH-1:0] pc;

  assign step = en && (pc == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (en)   pc <= (pc == '0) ? pre : pc - 1'b1;
  end
`else
  assign step = en;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clktick_chan #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .step  (step),
      .n     (n[i*WIDTH +: WIDTH]),
      .mode  (mode[i]),
      .start (start[i]),
      .stop  (stop[i]),
      .tick  (tick[i]),
      .busy  (busy[i])
    );
  end
endmodule

// File: tb/tb_clktick_multi.sv
// Directed testbench for clktick_multi (default build; the prescaler case is
// compiled in only when CLKTICK_PRESCALE_EN is defined).
module tb_clktick_multi;
  localparam int W   = 16;
  localparam int NCH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NCH*W-1:0]     n;
  logic [NCH-1:0]       mode, start, stop;
  logic [NCH-1:0]       tick, busy;
`ifdef CLKTICK_PRESCALE_EN
  logic [7:0]           pre;
`endif

  int errors = 0;
  int checks = 0;

  clktick_multi #(.WIDTH(W), .NCH(NCH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .n     (n),
    .mode  (mode),
    .start (start),
    .stop  (stop),
`ifdef CLKTICK_PRESCALE_EN
    .pre   (pre),
`endif
    .tick  (tick),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NCH-1:0] seen;
    int last, gap;
    rst = 1'b1; en = 1'b0; n = '0; mode = '0; start = '0; stop = '0;
`ifdef CLKTICK_PRESCALE_EN
    pre = '0;
`endif
    #1;
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // One-shot ch0 n=3: busy after edges k..k+3, tick after k+4 with busy low.
    n[0*W +: W] = 16'd3; mode[0] = 1'b0; en = 1'b1; start[0] = 1'b1;
    cyc(); start[0] = 1'b0;                         // edge k
    chk("os_busy_k", 32'(busy), 32'h1);
    chk("os_tick_k", 32'(tick), 32'h0);
    for (int e = 1; e <= 3; e++) begin
      cyc();
      chk($sformatf("os_busy_k+%0d", e), 32'(busy), 32'h1);
      chk($sformatf("os_tick_k+%0d", e), 32'(tick), 32'h0);
    end
    cyc();                                          // edge k+4
    chk("os_tick_term", 32'(tick), 32'h1);
    chk("os_busy_term", 32'(busy), 32'h0);
    cyc();
    chk("os_tick_after", 32'(tick), 32'h0);

    // Periodic ch1 n=2, changed to 5 after edge k+4: ticks at k+3, k+6, k+12.
    n[1*W +: W] = 16'd2; mode[1] = 1'b1; start[1] = 1'b1;
    cyc(); start[1] = 1'b0;                         // edge k
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk($sformatf("per_tick_k+%0d", e), 32'(tick),
          (e == 3 || e == 6 || e == 12) ? 32'h2 : 32'h0);
      if (e == 4) n[1*W +: W] = 16'd5;
    end
    stop[1] = 1'b1;
    cyc(); stop[1] = 1'b0;
    chk("per_stop_busy", 32'(busy), 32'h0);
    chk("per_stop_tick", 32'(tick), 32'h0);

    // Enable gating ch2 n=4 periodic, en = 1 on odd edges: ticks at k+9, k+19.
    n[2*W +: W] = 16'd4; mode[2] = 1'b1; start[2] = 1'b1;
    cyc(); start[2] = 1'b0;                         // edge k
    for (int j = 1; j <= 20; j++) begin
      en = (j % 2 == 1);
      cyc();
      chk($sformatf("en_tick_k+%0d", j), 32'(tick),
          (j == 9 || j == 19) ? 32'h4 : 32'h0);
    end
    stop[2] = 1'b1; en = 1'b1;
    cyc(); stop[2] = 1'b0;
    chk("en_stop_busy", 32'(busy), 32'h0);

    // Priority ch3: start+stop together -> IDLE with no tick.
    n[3*W +: W] = 16'd6; mode[3] = 1'b1; start[3] = 1'b1;
    cyc(); start[3] = 1'b0;
    cyc(); cyc();
    start[3] = 1'b1; stop[3] = 1'b1;
    cyc(); start[3] = 1'b0; stop[3] = 1'b0;
    chk("prio_busy", 32'(busy), 32'h0);
    chk("prio_tick", 32'(tick), 32'h0);
    // Restart alone at k+3 with n=3 delays the tick from k+4 to k+7.
    n[3*W +: W] = 16'd3; start[3] = 1'b1;
    cyc(); start[3] = 1'b0;                         // edge k
    for (int e = 1; e <= 7; e++) begin
      start[3] = (e == 3);
      cyc();
      chk($sformatf("restart_tick_k+%0d", e), 32'(tick), (e == 7) ? 32'h8 : 32'h0);
      chk($sformatf("restart_busy_k+%0d", e), 32'(busy), 32'h8);
    end
    start[3] = 1'b0; stop[3] = 1'b1;
    cyc(); stop[3] = 1'b0;

    // Periodic n=0 with step held high: tick on every edge.
    n[0*W +: W] = 16'd0; mode[0] = 1'b1; start[0] = 1'b1;
    cyc(); start[0] = 1'b0;
    chk("n0_tick_k", 32'(tick), 32'h0);
    for (int e = 1; e <= 4; e++) begin
      cyc();
      chk($sformatf("n0_tick_k+%0d", e), 32'(tick), 32'h1);
    end
    stop[0] = 1'b1;
    cyc(); stop[0] = 1'b0;

    // Asynchronous reset mid-run on all channels.
    n = {4{16'd10}}; mode = '1; start = '1;
    cyc(); start = '0;
    cyc(); cyc();
    chk("pre_rst_busy", 32'(busy), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    cyc();
    rst = 1'b0;
    seen = '0;
    for (int e = 0; e < 15; e++) begin
      cyc();
      seen |= tick | busy;
    end
    chk("post_rst_quiet", 32'(seen), 32'h0);

`ifdef CLKTICK_PRESCALE_EN
    // pre=1, ch0 n=1 periodic: ticks every 4 cycles (phase unaligned).
    pre = 8'd1; n[0*W +: W] = 16'd1; mode[0] = 1'b1; start[0] = 1'b1;
    cyc(); start[0] = 1'b0;
    last = -1;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (tick[0]) begin
        if (last >= 0) begin
          gap = e - last;
          chk("pre_gap", 32'(gap), 32'd4);
        end
        last = e;
      end
    end
    chk("pre_ticked", 32'(last >= 0), 32'h1);
`else
    last = 0; gap = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
